// File: rtl/cmd_mem_loader.sv
// Command memory loader: packs MEM_TO_CMD input words into one command and
// writes it to the command bank at consecutive addresses from a programmed base.
module cmd_mem_loader #(
  parameter int CMD_WIDTH      = 128,
  parameter int MEM_WIDTH      = 32,
  parameter int CMD_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_start,
  input  logic [CMD_ADDR_WIDTH-1:0] start_addr,
  input  logic [CMD_ADDR_WIDTH:0]   load_len,
  input  logic                      abort,
  input  logic [MEM_WIDTH-1:0]      word_in,
  input  logic                      word_valid,
  output logic                      word_ready,
  output logic [CMD_WIDTH-1:0]      cmd_write,
  output logic [CMD_ADDR_WIDTH-1:0] cmd_write_addr,
  output logic                      cmd_write_enable,
  output logic                      busy,
  output logic                      done,
  output logic [CMD_ADDR_WIDTH:0]   cmds_written
);

  localparam int MEM_TO_CMD = CMD_WIDTH / MEM_WIDTH;
  localparam int IDX_W      = (MEM_TO_CMD > 1) ? $clog2(MEM_TO_CMD) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CMD_WIDTH-1:0]      pack_q, pack_d;
  logic [CMD_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CMD_ADDR_WIDTH:0]   len_q, len_d;
  logic [CMD_ADDR_WIDTH:0]   cnt_q, cnt_d, cnt_inc;
  logic                      ready_q, ready_d;
  logic [CMD_WIDTH-1:0]      wdata_q, wdata_d;
  logic [CMD_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                      we_q, we_d;
  logic                      done_q, done_d;
  logic                      accept;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pack_d  = pack_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    cnt_inc = cnt_q + 1'b1;
    accept  = word_valid & ready_q;

    case (state_q)
      IDLE: begin
        if (load_start) begin
          cnt_d = '0;
          if (load_len != '0) begin
            state_d = LOAD;
            ready_d = 1'b1;
            addr_d  = start_addr;
            len_d   = load_len;
            idx_d   = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      LOAD: begin
        // abort outranks a word arriving in the same cycle, even a completing one
        if (abort) begin
          state_d = IDLE;
          ready_d = 1'b0;
          idx_d   = '0;
        end else if (accept) begin
          for (int unsigned k = 0; k < MEM_TO_CMD; k++) begin
            if (idx_q == IDX_W'(k)) pack_d[k*MEM_WIDTH +: MEM_WIDTH] = word_in;
          end
          if (idx_q == IDX_W'(MEM_TO_CMD - 1)) begin
            idx_d   = '0;
            we_d    = 1'b1;
            wdata_d = pack_d;
            waddr_d = addr_q;
            addr_d  = addr_q + 1'b1;
            cnt_d   = cnt_inc;
            if (cnt_inc == len_q) begin
              state_d = FLUSH;
              ready_d = 1'b0;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pack_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pack_q  <= pack_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  assign word_ready       = ready_q;
  assign cmd_write        = wdata_q;
  assign cmd_write_addr   = waddr_q;
  assign cmd_write_enable = we_q;
  assign busy             = (state_q == LOAD);
  assign done             = done_q;
  assign cmds_written     = cnt_q;

endmodule

// File: tb/tb_cmd_mem_loader.sv
// Bench for cmd_mem_loader: directed scenarios plus randomized traffic, every
// cycle compared against a word-queue model of the loader.
module tb_cmd_mem_loader;
  localparam int CW = 128;
  localparam int MW = 32;
  localparam int AW = 16;
  localparam int M  = CW / MW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1, load_start = 1'b0, abort = 1'b0, word_valid = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   load_len = '0;
  logic [MW-1:0] word_in = '0;
  logic          word_ready, cmd_write_enable, busy, done;
  logic [CW-1:0] cmd_write;
  logic [AW-1:0] cmd_write_addr;
  logic [AW:0]   cmds_written;

  cmd_mem_loader #(.CMD_WIDTH(CW), .MEM_WIDTH(MW), .CMD_ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .start_addr(start_addr),
    .load_len(load_len), .abort(abort), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .cmd_write(cmd_write), .cmd_write_addr(cmd_write_addr),
    .cmd_write_enable(cmd_write_enable), .busy(busy), .done(done),
    .cmds_written(cmds_written)
  );

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: loading flag, queue of accepted words, next address, remaining budget.
  bit            m_active = 0, m_fin = 0;
  logic [MW-1:0] m_words[$];
  logic [AW-1:0] m_addr;
  logic [AW:0]   m_len;
  logic          exp_ready, exp_we, exp_busy, exp_done;
  logic [CW-1:0] exp_wdata;
  logic [AW-1:0] exp_waddr;
  logic [AW:0]   exp_cnt;
  logic [AW-1:0] mlog_addr[$];
  logic [CW-1:0] mlog_data[$];
  int            cyc = 0;

  always @(posedge clk) begin
    logic [CW-1:0] d;
    cyc++;
    if (reset) begin
      m_active = 0; m_fin = 0; m_words.delete();
      exp_ready = 0; exp_we = 0; exp_busy = 0; exp_done = 0;
      exp_wdata = '0; exp_waddr = '0; exp_cnt = '0;
    end else begin
      exp_we = 0;
      exp_done = 0;
      if (m_fin) begin
        m_fin = 0;
        exp_done = 1;
      end else if (!m_active) begin
        if (load_start) begin
          exp_cnt = '0;
          if (load_len == 0) exp_done = 1;
          else begin
            m_active = 1; m_addr = start_addr; m_len = load_len; m_words.delete();
          end
        end
      end else if (abort) begin
        m_active = 0;
        m_words.delete();
      end else if (word_valid) begin
        m_words.push_back(word_in);
        if (m_words.size() == M) begin
          d = '0;
          foreach (m_words[k]) d |= CW'(m_words[k]) << (MW * k);
          exp_we = 1; exp_wdata = d; exp_waddr = m_addr;
          mlog_addr.push_back(m_addr); mlog_data.push_back(d);
          m_addr = m_addr + 1'b1;
          exp_cnt = exp_cnt + 1'b1;
          m_words.delete();
          if (exp_cnt == m_len) begin
            m_active = 0;
            m_fin = 1;
          end
        end
      end
      exp_ready = m_active;
      exp_busy  = m_active;
    end
  end

  bit            chk_en = 0;
  logic [AW-1:0] dlog_addr[$];
  logic [CW-1:0] dlog_data[$];
  int            done_n = 0, busy_seen = 0, last_we_cyc = 0, last_done_cyc = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("word_ready", CW'(word_ready), CW'(exp_ready));
      chk("cmd_write_enable", CW'(cmd_write_enable), CW'(exp_we));
      chk("cmd_write", cmd_write, exp_wdata);
      chk("cmd_write_addr", CW'(cmd_write_addr), CW'(exp_waddr));
      chk("busy", CW'(busy), CW'(exp_busy));
      chk("done", CW'(done), CW'(exp_done));
      chk("cmds_written", CW'(cmds_written), CW'(exp_cnt));
      if (cmd_write_enable) begin
        dlog_addr.push_back(cmd_write_addr);
        dlog_data.push_back(cmd_write);
        last_we_cyc = cyc;
      end
      if (done) begin done_n++; last_done_cyc = cyc; end
      if (busy) busy_seen = 1;
    end
  end

  task automatic clr();
    dlog_addr.delete(); dlog_data.delete(); mlog_addr.delete(); mlog_data.delete();
    done_n = 0; busy_seen = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input logic [AW-1:0] a, input logic [AW:0] l);
    load_start = 1; start_addr = a; load_len = l;
    @(negedge clk);
    load_start = 0;
  endtask

  task automatic send(input int n, input logic [MW-1:0] base, input bit gapped);
    for (int i = 0; i < n; i++) begin
      word_valid = 1; word_in = base + MW'(i);
      @(negedge clk);
      if (gapped) begin word_valid = 0; @(negedge clk); end
    end
    word_valid = 0;
  endtask

  task automatic chk_basic_pair(input string tag);
    chk({tag, "_nwr"}, CW'(dlog_addr.size()), CW'(2));
    chk({tag, "_a0"}, CW'(dlog_addr[0]), CW'(16'h0010));
    chk({tag, "_d0"}, dlog_data[0], 128'h00000003_00000002_00000001_00000000);
    chk({tag, "_a1"}, CW'(dlog_addr[1]), CW'(16'h0011));
    chk({tag, "_d1"}, dlog_data[1], 128'h00000007_00000006_00000005_00000004);
    chk({tag, "_done_n"}, CW'(done_n), CW'(1));
    chk({tag, "_done_lat"}, CW'(last_done_cyc - last_we_cyc), CW'(1));
    chk({tag, "_cnt"}, CW'(cmds_written), CW'(2));
    chk({tag, "_ready_off"}, CW'(word_ready), CW'(0));
  endtask

  initial begin
    @(negedge clk);
    chk_en = 1;
    chk("rst_ready", CW'(word_ready), CW'(0));
    chk("rst_cnt", CW'(cmds_written), CW'(0));
    chk("rst_wdata", cmd_write, CW'(0));
    reset = 0;

    // basic load, then words after completion must be ignored
    clr(); start(16'h0010, 2); send(8, 0, 0); send(2, 32'h100, 0); idle(3);
    chk_basic_pair("basic");
    chk("model_d0", mlog_data[0], 128'h00000003_00000002_00000001_00000000);
    chk("model_a1", CW'(mlog_addr[1]), CW'(16'h0011));

    clr(); start(16'h0010, 2); send(8, 0, 1); idle(3);
    chk_basic_pair("gapped");

    clr(); start(16'hFFFF, 2); send(8, 32'hA0, 0); idle(3);
    chk("wrap_a0", CW'(dlog_addr[0]), CW'(16'hFFFF));
    chk("wrap_a1", CW'(dlog_addr[1]), CW'(16'h0000));
    chk("wrap_done", CW'(done_n), CW'(1));

    clr(); start(16'h0020, 3); send(6, 32'h10, 0);
    abort = 1; @(negedge clk); abort = 0;
    chk("abort_busy", CW'(busy), CW'(0));
    chk("abort_cnt", CW'(cmds_written), CW'(1));
    idle(3);
    chk("abort_nwr", CW'(dlog_addr.size()), CW'(1));
    chk("abort_a0", CW'(dlog_addr[0]), CW'(16'h0020));
    chk("abort_nodone", CW'(done_n), CW'(0));
    start(16'h0030, 1); send(4, 32'h20, 0); idle(3);
    chk("reload_a", CW'(dlog_addr[1]), CW'(16'h0030));
    chk("reload_done", CW'(done_n), CW'(1));

    clr(); start(16'h0060, 0); idle(3);
    chk("zero_done", CW'(done_n), CW'(1));
    chk("zero_nwr", CW'(dlog_addr.size()), CW'(0));
    chk("zero_busy", CW'(busy_seen), CW'(0));

    clr(); start(16'h0100, 2); send(2, 32'h30, 0);
    load_start = 1; start_addr = 16'h5555; load_len = 1;
    send(1, 32'h32, 0); load_start = 0;
    send(5, 32'h33, 0); idle(3);
    chk("ign_a0", CW'(dlog_addr[0]), CW'(16'h0100));
    chk("ign_a1", CW'(dlog_addr[1]), CW'(16'h0101));
    chk("ign_cnt", CW'(cmds_written), CW'(2));

    clr(); start(16'h0040, 1); send(2, 32'h40, 0);
    reset = 1; @(negedge clk);
    chk("rstmid_we", CW'(cmd_write_enable), CW'(0));
    chk("rstmid_busy", CW'(busy), CW'(0));
    chk("rstmid_wdata", cmd_write, CW'(0));
    chk("rstmid_waddr", CW'(cmd_write_addr), CW'(0));
    reset = 0;
    start(16'h0050, 1); send(4, 32'hC0, 0); idle(3);
    chk("rstmid_nwr", CW'(dlog_addr.size()), CW'(1));
    chk("rstmid_a", CW'(dlog_addr[0]), CW'(16'h0050));
    chk("rstmid_d", dlog_data[0], 128'h000000C3_000000C2_000000C1_000000C0);

    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 499) == 0);
      load_start = ($urandom_range(0, 7) == 0);
      load_len   = (AW+1)'($urandom_range(0, 3));
      start_addr = ($urandom_range(0, 3) == 0) ? AW'(16'hFFFF - $urandom_range(0, 2)) : AW'($urandom);
      abort      = ($urandom_range(0, 39) == 0);
      word_valid = ($urandom_range(0, 9) < 7);
      word_in    = $urandom;
      @(negedge clk);
    end
    reset = 0; load_start = 0; abort = 0; word_valid = 0;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
